// File: rtl/elevator_request_scheduler.sv
// Elevator call scheduler: latches floor calls and sweeps up/down, targeting the nearest call ahead.
// Build option: define SCHED_EMERGENCY_CLEAR_EN to drop all pending calls while Emergency is high.
module elevator_request_scheduler #(
  parameter int NUM_FLOORS = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        Emergency,
  input  logic [15:0] call_button,
  input  logic [3:0]  current_floor,
  input  logic        door_status,
  output logic [3:0]  floor_request,
  output logic        req_valid,
  output logic [15:0] pending,
  output logic [1:0]  sched_dir
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    UP   = 2'b01,
    DOWN = 2'b10
  } state_t;

  state_t      state_reg, state_next, eval_state;
  logic [15:0] pending_reg, pending_next;
  logic [3:0]  floor_request_reg, floor_request_next;
  logic        req_valid_reg, req_valid_next;
  logic        emergency_d_reg;

  logic [15:0] floor_mask, set_vec, clr_vec, above_vec, below_vec;
  logic [3:0]  cur_eff, lowest_above, highest_below;
  logic        at_floor, any_above, any_below, prefer_down;

  // Out-of-range floor reports are clamped to the top served floor.
  assign cur_eff = ({1'b0, current_floor} >= 5'(NUM_FLOORS)) ? 4'(NUM_FLOORS - 1) : current_floor;

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_floor
      assign floor_mask[gi] = (gi < NUM_FLOORS);
      assign set_vec[gi]    = call_button[gi] & floor_mask[gi];
      assign clr_vec[gi]    = door_status && (cur_eff == 4'(gi));
      assign above_vec[gi]  = pending_reg[gi] && (4'(gi) > cur_eff);
      assign below_vec[gi]  = pending_reg[gi] && (4'(gi) < cur_eff);
    end
  endgenerate

  assign at_floor  = pending_reg[cur_eff];
  assign any_above = |above_vec;
  assign any_below = |below_vec;

  always_comb begin
    lowest_above = '0;
    for (int i = 15; i >= 0; i--)
      if (above_vec[i]) lowest_above = 4'(i);
  end

  always_comb begin
    highest_below = '0;
    for (int i = 0; i < 16; i++)
      if (below_vec[i]) highest_below = 4'(i);
  end

  // A served call clears after the set term so that clear wins on a same-cycle press.
  always_comb begin
    pending_next = (pending_reg | set_vec) & ~clr_vec;
    if (Emergency) begin
`ifdef SCHED_EMERGENCY_CLEAR_EN
      pending_next = '0;
`else
      pending_next = pending_reg;
`endif
    end
  end

  // The first cycle after an emergency ends re-evaluates as if idle.
  assign eval_state  = emergency_d_reg ? IDLE : state_reg;
  assign prefer_down = (eval_state == DOWN);

  always_comb begin
    state_next         = state_reg;
    floor_request_next = floor_request_reg;
    req_valid_next     = req_valid_reg;
    if (!Emergency) begin
      if (at_floor) begin
        state_next         = eval_state;
        floor_request_next = cur_eff;
        req_valid_next     = 1'b1;
      end else if (any_below && (prefer_down || !any_above)) begin
        state_next         = DOWN;
        floor_request_next = highest_below;
        req_valid_next     = 1'b1;
      end else if (any_above) begin
        state_next         = UP;
        floor_request_next = lowest_above;
        req_valid_next     = 1'b1;
      end else begin
        state_next         = IDLE;
        floor_request_next = cur_eff;
        req_valid_next     = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg         <= IDLE;
      pending_reg       <= '0;
      floor_request_reg <= '0;
      req_valid_reg     <= 1'b0;
      emergency_d_reg   <= 1'b0;
    end else begin
      state_reg         <= state_next;
      pending_reg       <= pending_next;
      floor_request_reg <= floor_request_next;
      req_valid_reg     <= req_valid_next;
      emergency_d_reg   <= Emergency;
    end
  end

  assign pending       = pending_reg;
  assign floor_request = floor_request_reg;
  assign req_valid     = req_valid_reg;
  assign sched_dir     = state_reg;

endmodule

// File: tb/tb_elevator_request_scheduler.sv
// Directed bench for elevator_request_scheduler with hand-computed expectations.
module tb_elevator_request_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        Emergency;
  logic [15:0] call_button;
  logic [3:0]  current_floor;
  logic        door_status;
  logic [3:0]  floor_request;
  logic        req_valid;
  logic [15:0] pending;
  logic [1:0]  sched_dir;

  int checks = 0;
  int errors = 0;

  elevator_request_scheduler #(.NUM_FLOORS(8)) dut (
    .clk           (clk),
    .reset         (reset),
    .Emergency     (Emergency),
    .call_button   (call_button),
    .current_floor (current_floor),
    .door_status   (door_status),
    .floor_request (floor_request),
    .req_valid     (req_valid),
    .pending       (pending),
    .sched_dir     (sched_dir)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
    $display("check %-16s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic chk_out(input string tag, input logic [3:0] fr, input logic v, input logic [1:0] dir);
    chk({tag, ".floor"}, 16'(floor_request), 16'(fr));
    chk({tag, ".valid"}, 16'(req_valid), 16'(v));
    chk({tag, ".dir"},   16'(sched_dir), 16'(dir));
  endtask

  initial begin
    reset = 1'b1; Emergency = 1'b0; call_button = '0; current_floor = '0; door_status = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("rst.pending", pending, 16'h0000);
    chk_out("rst", 4'd0, 1'b0, 2'b00);
    tick(); tick();
    reset = 1'b1;
    tick();
    chk_out("post_rst", 4'd0, 1'b0, 2'b00);

    // Single call above: pending first, outputs one cycle later
    call_button = 16'h0020; tick();
    chk("c5.pending", pending, 16'h0020);
    chk("c5.valid_lag", 16'(req_valid), 16'd0);
    call_button = '0; tick();
    chk_out("c5", 4'd5, 1'b1, 2'b01);

    // Sweep up through 4,5,6 from floor 3, then reverse to 1
    current_floor = 4'd3; call_button = 16'h0052; tick();
    chk("sweep.pending", pending, 16'h0072);
    call_button = '0; tick();
    chk_out("sweep.f3", 4'd4, 1'b1, 2'b01);
    current_floor = 4'd4; door_status = 1'b1; tick();
    chk("serve4.pending", pending, 16'h0062);
    chk_out("serve4", 4'd4, 1'b1, 2'b01);
    current_floor = 4'd5; tick();
    chk("serve5.pending", pending, 16'h0042);
    current_floor = 4'd6; tick();
    chk("serve6.pending", pending, 16'h0002);
    door_status = 1'b0; tick();
    chk_out("reverse", 4'd1, 1'b1, 2'b10);
    current_floor = 4'd1; door_status = 1'b1; tick();
    door_status = 1'b0; tick();
    chk("drain.pending", pending, 16'h0000);
    chk_out("drain", 4'd1, 1'b0, 2'b00);

    // Press at the floor with the door open: clear wins
    current_floor = 4'd2; door_status = 1'b1; tick();
    call_button = 16'h0004; tick(); tick();
    chk("atfloor.pending", pending, 16'h0000);
    chk_out("atfloor", 4'd2, 1'b0, 2'b00);
    call_button = '0; door_status = 1'b0;

    // Buttons beyond NUM_FLOORS are ignored
    call_button = 16'hFF00; tick(); tick();
    chk("hi.pending", pending, 16'h0000);
    chk("hi.valid", 16'(req_valid), 16'd0);
    call_button = '0;

    // Out-of-range floor treated as floor 7: a call at 3 lies below
    current_floor = 4'hC; call_button = 16'h0008; tick();
    call_button = '0; tick();
    chk_out("clamp", 4'd3, 1'b1, 2'b10);
    current_floor = 4'd3; door_status = 1'b1; tick();
    door_status = 1'b0; tick();
    chk("clamp.pending", pending, 16'h0000);

    // Emergency freeze and release
    current_floor = 4'd0; call_button = 16'h00A0; tick();
    call_button = '0; tick();
    chk_out("pre_emg", 4'd5, 1'b1, 2'b01);
    Emergency = 1'b1; current_floor = 4'd6; call_button = 16'h0001; tick();
    chk_out("emg1", 4'd5, 1'b1, 2'b01);
    tick();
    chk_out("emg2", 4'd5, 1'b1, 2'b01);
`ifdef SCHED_EMERGENCY_CLEAR_EN
    chk("emg.pending", pending, 16'h0000);
`else
    chk("emg.pending", pending, 16'h00A0);
`endif
    Emergency = 1'b0; call_button = '0; tick();
`ifdef SCHED_EMERGENCY_CLEAR_EN
    chk_out("emg_rel", 4'd6, 1'b0, 2'b00);
`else
    chk_out("emg_rel", 4'd7, 1'b1, 2'b01);
`endif

    // Asynchronous reset mid-cycle discards calls
    call_button = 16'h0044; tick();
    call_button = '0; tick();
    chk("prerst.valid", 16'(req_valid), 16'd1);
    #2 reset = 1'b0;
    #1;
    chk("arst.pending", pending, 16'h0000);
    chk_out("arst", 4'd0, 1'b0, 2'b00);
    current_floor = 4'd0;
    #3 reset = 1'b1;
    tick(); tick();
    chk("after_rst.pending", pending, 16'h0000);
    chk_out("after_rst", 4'd0, 1'b0, 2'b00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/elevator_request_scheduler.md
ELEVATOR_REQUEST_SCHEDULER -- requirements
Module: elevator_request_scheduler

Interface
REQ-001 Parameter NUM_FLOORS, default 8, number of served floors (2..16); floors are numbered 0..NUM_FLOORS-1.
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset.
REQ-004 Emergency  input  1  emergency stop, shared with the elevator controller.
REQ-005 call_button  input  16  one bit per floor; a high level registers a call; bits >= NUM_FLOORS are ignored.
REQ-006 current_floor  input  4  floor reported by the elevator controller.
REQ-007 door_status  input  1  controller door state; 1 = open.
REQ-008 floor_request  output  4  target floor driven to the elevator controller.
REQ-009 req_valid  output  1  1 = floor_request is a pending call; 0 = no call pending.
REQ-010 pending  output  16  registered call bitmap, used for button lamps.
REQ-011 sched_dir  output  2  scheduler sweep: 00 idle, 01 up, 10 down; 11 never driven.

Function
REQ-012 pending[i] SHALL set on the cycle after call_button[i]=1, for i < NUM_FLOORS.
REQ-013 pending[i] SHALL clear on the cycle after current_floor==i while door_status==1 (call served).
REQ-014 A set and a clear of the same bit in the same cycle: clear SHALL win.
REQ-015 FSM states: IDLE, UP, DOWN; sched_dir encodes the state.
REQ-016 IDLE: any pending above current_floor -> UP; else any pending below -> DOWN; else stay IDLE; if both exist, UP wins.
REQ-017 UP: target = lowest pending floor > current_floor; if none, go DOWN if any pending below, else IDLE.
REQ-018 DOWN: target = highest pending floor < current_floor; if none, go UP if any pending above, else IDLE.
REQ-019 A pending call at current_floor SHALL be targeted in any state: floor_request=current_floor, req_valid=1, state unchanged.
REQ-020 floor_request, req_valid and sched_dir SHALL be registered, updating one cycle after the pending/current_floor change that causes them.
REQ-021 With no pending calls: req_valid=0, floor_request=current_floor, sched_dir=00.
REQ-022 current_floor values >= NUM_FLOORS SHALL be treated as NUM_FLOORS-1 for comparison.
REQ-023 While Emergency=1: floor_request, req_valid and sched_dir SHALL be frozen at their current values; no new calls set (pending handling per REQ-030/031).
REQ-024 On Emergency falling edge, the scheduler SHALL resume from IDLE evaluation on the next cycle.
REQ-025 Multiple simultaneous call_button bits SHALL all be registered in one cycle.

Reset
REQ-026 reset=0 SHALL immediately clear pending to 0, floor_request to 0, req_valid to 0, sched_dir to 00, FSM to IDLE.
REQ-027 Reset asserted mid-sweep SHALL discard all calls; no call is restored after release.
REQ-028 First evaluation SHALL occur on the first rising clk edge after reset returns high.

Configuration
REQ-029 Macro SCHED_EMERGENCY_CLEAR_EN selects emergency call handling.
REQ-030 Defined: each cycle with Emergency=1 SHALL clear all pending bits.
REQ-031 Undefined: pending SHALL be held unchanged during Emergency and served after release.

Verification
REQ-032 Reset, current_floor=0, call_button bit5 one cycle -> pending=0x0020, then floor_request=5, req_valid=1, sched_dir=01 one cycle later.
REQ-033 current_floor=3, state UP, pending floors 1,4,6 -> floor_request=4; after current_floor=4 with door_status=1 -> bit4 clears, floor_request=6; after floor 6 served -> DOWN, floor_request=1.
REQ-034 current_floor=2, door_status=1, call_button bit2 held -> pending bit2 stays 0; floor_request unchanged.
REQ-035 pending floor 7, Emergency=1 for 2 cycles -> outputs frozen; with SCHED_EMERGENCY_CLEAR_EN pending=0 and req_valid=0 after release, without it floor_request=7 after release.
REQ-036 pending floors 2 and 6, reset pulsed low mid-cycle -> all outputs 0 immediately, pending stays 0 after release.
REQ-037 NUM_FLOORS=8, call_button=0xFF00 -> pending stays 0, req_valid=0.
